// File: rtl/mdio_master_v2.sv
// Clause-22 MDIO management master: runs one read or write frame per accepted
// command, generating MDC from the system clock and returning read data.
module mdio_master_v2 #(
   parameter int CLKS_PER_HALF_MDC = 63,
   parameter int PREAMBLE_BITS     = 32
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic        i_cmd_write,
   input  logic [4:0]  i_cmd_phy_addr,
   input  logic [4:0]  i_cmd_reg_addr,
   input  logic [15:0] i_cmd_wdata,
   output logic        o_rsp_valid,
   output logic [15:0] o_rsp_rdata,
   output logic        o_rsp_error,
   output logic        o_mdc,
   input  logic        i_mdio_i,
   output logic        o_mdio_o,
   output logic        o_mdio_t
);

   localparam int CNT_W = $clog2(33) + 1;
   localparam int PH_W  = $clog2(2 * CLKS_PER_HALF_MDC);

   localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(CLKS_PER_HALF_MDC - 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLKS_PER_HALF_MDC - 1);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
   localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(13);
   localparam logic [CNT_W-1:0] TA_LAST  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(15);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_HEADER,
      S_TURNAROUND,
      S_DATA,
      S_RESPOND
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic [PH_W-1:0]  r_phase;
   logic [CNT_W-1:0] r_bitCnt;
   logic [31:0]      r_frame;
   logic             r_write;
   logic             r_taErr;
   logic [15:0]      r_rxShift;

   logic             r_cmdReady;
   logic             r_rspValid;
   logic [15:0]      r_rspRdata;
   logic             r_rspError;
   logic             r_mdc;
   logic             r_mdioO;
   logic             r_mdioT;

   logic             w_handshake;
   logic             w_slotEnd;
   logic             w_inFrame;
   logic             w_nextInFrame;
   logic             w_newSlot;
   logic             w_release;
   logic             w_nextBit;
   logic             w_respondEntry;
   logic [31:0]      w_cmdFrame;

   assign w_handshake    = i_cmd_valid && r_cmdReady && (r_state == S_IDLE);
   assign w_slotEnd      = (r_phase == PH_LAST);
   assign w_inFrame      = (r_state == S_PREAMBLE) || (r_state == S_HEADER) ||
                           (r_state == S_TURNAROUND) || (r_state == S_DATA);
   assign w_nextInFrame  = (w_nextState == S_PREAMBLE) || (w_nextState == S_HEADER) ||
                           (w_nextState == S_TURNAROUND) || (w_nextState == S_DATA);
   assign w_newSlot      = w_nextInFrame && ((r_state == S_IDLE) || w_slotEnd);
   assign w_respondEntry = (r_state == S_DATA) && (w_nextState == S_RESPOND);
   assign w_cmdFrame     = {2'b01, (i_cmd_write ? 2'b01 : 2'b10), i_cmd_phy_addr,
                            i_cmd_reg_addr, 2'b10, i_cmd_wdata};

   // Reads hand the bus to the PHY from the first turnaround bit onwards.
   assign w_release = !r_write && ((w_nextState == S_TURNAROUND) || (w_nextState == S_DATA));
   assign w_nextBit = (w_nextState == S_PREAMBLE) ? 1'b1 :
                      (w_handshake ? w_cmdFrame[31] : r_frame[31]);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_handshake) begin
               w_nextState = (PREAMBLE_BITS == 0) ? S_HEADER : S_PREAMBLE;
            end
         end
         S_PREAMBLE: begin
            if (w_slotEnd && (r_bitCnt == PRE_LAST)) w_nextState = S_HEADER;
         end
         S_HEADER: begin
            if (w_slotEnd && (r_bitCnt == HDR_LAST)) w_nextState = S_TURNAROUND;
         end
         S_TURNAROUND: begin
            if (w_slotEnd && (r_bitCnt == TA_LAST)) w_nextState = S_DATA;
         end
         S_DATA: begin
            if (w_slotEnd && (r_bitCnt == DAT_LAST)) w_nextState = S_RESPOND;
         end
         S_RESPOND: w_nextState = S_IDLE;
         default:   w_nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_phase    <= '0;
         r_bitCnt   <= '0;
         r_frame    <= '0;
         r_write    <= 1'b0;
         r_taErr    <= 1'b0;
         r_rxShift  <= '0;
         r_cmdReady <= 1'b0;
         r_rspValid <= 1'b0;
         r_rspRdata <= '0;
         r_rspError <= 1'b0;
         r_mdc      <= 1'b0;
         r_mdioO    <= 1'b0;
         r_mdioT    <= 1'b1;
      end else begin
         r_rspValid <= 1'b0;
         r_cmdReady <= (w_nextState == S_IDLE);

         if (w_slotEnd || !w_inFrame) begin
            r_phase <= '0;
         end else begin
            r_phase <= r_phase + PH_W'(1);
         end

         if (w_nextState != r_state) begin
            r_bitCnt <= '0;
         end else if (w_slotEnd) begin
            r_bitCnt <= r_bitCnt + CNT_W'(1);
         end

         // The frame register holds the post-preamble bits, consumed MSB first.
         if (w_handshake) begin
            r_write <= i_cmd_write;
            r_taErr <= 1'b0;
            if (PREAMBLE_BITS == 0) begin
               r_frame <= {w_cmdFrame[30:0], 1'b0};
            end else begin
               r_frame <= w_cmdFrame;
            end
         end else if (w_newSlot && (w_nextState != S_PREAMBLE)) begin
            r_frame <= {r_frame[30:0], 1'b0};
         end

         if (w_newSlot) begin
            r_mdc   <= 1'b0;
            r_mdioO <= w_release ? 1'b0 : w_nextBit;
            r_mdioT <= w_release;
         end else if (w_respondEntry) begin
            r_mdc      <= 1'b0;
            r_mdioO    <= 1'b0;
            r_mdioT    <= 1'b1;
            r_rspValid <= 1'b1;
            if (r_write) begin
               r_rspError <= 1'b0;
            end else begin
               r_rspRdata <= r_rxShift;
               r_rspError <= r_taErr;
            end
         end else if (w_inFrame && (r_phase == PH_RISE)) begin
            r_mdc <= 1'b1;
            if (!r_write && (r_state == S_TURNAROUND) && (r_bitCnt == TA_LAST)) begin
               r_taErr <= i_mdio_i;
            end
            if (!r_write && (r_state == S_DATA)) begin
               r_rxShift <= {r_rxShift[14:0], i_mdio_i};
            end
         end
      end
   end

   assign o_cmd_ready = r_cmdReady;
   assign o_rsp_valid = r_rspValid;
   assign o_rsp_rdata = r_rspRdata;
   assign o_rsp_error = r_rspError;
   assign o_mdc       = r_mdc;
   assign o_mdio_o    = r_mdioO;
   assign o_mdio_t    = r_mdioT;

endmodule

// File: tb/tb_mdio_master_v2.sv
// Bench for mdio_master_v2: table of directed frames on an H=2/32-preamble
// instance plus hand sequences for reset, back-to-back and preamble suppression.
module tb_mdio_master_v2;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        cmdValid = 1'b0;
   logic        cmdWrite = 1'b0;
   logic [4:0]  cmdPhy = '0;
   logic [4:0]  cmdReg = '0;
   logic [15:0] cmdWdata = '0;
   logic        mdioI = 1'b1;
   logic        useB = 1'b0;

   logic        readyA, rspValidA, rspErrA, mdcA, mdioOA, mdioTA;
   logic        readyB, rspValidB, rspErrB, mdcB, mdioOB, mdioTB;
   logic [15:0] rdataA, rdataB;

   logic        selReady, selRsp, selErr, selMdc, selO, selT;
   logic [15:0] selRdata;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        wr;
      logic [4:0]  phy;
      logic [4:0]  rg;
      logic [15:0] wdata;
      logic [31:0] expFrame;
      int          phyMode;
      logic [15:0] phyData;
      int          pulseAt;
      logic [15:0] expRdata;
      logic        expErr;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mdio_master_v2 #(.CLKS_PER_HALF_MDC(2), .PREAMBLE_BITS(32)) dutA (
      .i_clk(clk), .i_reset_n(resetN), .i_cmd_valid(cmdValid && !useB), .o_cmd_ready(readyA),
      .i_cmd_write(cmdWrite), .i_cmd_phy_addr(cmdPhy), .i_cmd_reg_addr(cmdReg),
      .i_cmd_wdata(cmdWdata), .o_rsp_valid(rspValidA), .o_rsp_rdata(rdataA),
      .o_rsp_error(rspErrA), .o_mdc(mdcA), .i_mdio_i(mdioI), .o_mdio_o(mdioOA),
      .o_mdio_t(mdioTA)
   );

   mdio_master_v2 #(.CLKS_PER_HALF_MDC(3), .PREAMBLE_BITS(0)) dutB (
      .i_clk(clk), .i_reset_n(resetN), .i_cmd_valid(cmdValid && useB), .o_cmd_ready(readyB),
      .i_cmd_write(cmdWrite), .i_cmd_phy_addr(cmdPhy), .i_cmd_reg_addr(cmdReg),
      .i_cmd_wdata(cmdWdata), .o_rsp_valid(rspValidB), .o_rsp_rdata(rdataB),
      .o_rsp_error(rspErrB), .o_mdc(mdcB), .i_mdio_i(mdioI), .o_mdio_o(mdioOB),
      .o_mdio_t(mdioTB)
   );

   assign selReady = useB ? readyB    : readyA;
   assign selRsp   = useB ? rspValidB : rspValidA;
   assign selErr   = useB ? rspErrB   : rspErrA;
   assign selMdc   = useB ? mdcB      : mdcA;
   assign selO     = useB ? mdioOB    : mdioOA;
   assign selT     = useB ? mdioTB    : mdioTA;
   assign selRdata = useB ? rdataB    : rdataA;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Runs one frame on the selected instance with a cycle-accurate PHY model.
   task automatic applyStimulus(input vec_t v, input bit onB, input string name);
      int h, p, n, t0, rel, slot, ph, waitCnt;
      bit bitsOk, tOk, mdcOk, quietOk, expDrive;
      logic expBit;
      h = onB ? 3 : 2;
      p = onB ? 0 : 32;
      n = p + 32;
      bitsOk = 1'b1; tOk = 1'b1; mdcOk = 1'b1; quietOk = 1'b1;
      useB = onB;
      mdioI = 1'b1;
      #0;
      waitCnt = 0;
      while (!selReady && waitCnt < 20) begin
         tick();
         waitCnt++;
      end
      checkOutput({name, " readyBeforeCmd"}, {31'd0, selReady}, 32'd1);
      if (!selReady) return;
      cmdWrite = v.wr; cmdPhy = v.phy; cmdReg = v.rg; cmdWdata = v.wdata;
      cmdValid = 1'b1;
      t0 = cyc;
      tick();
      cmdValid = 1'b0;
      for (int t = t0 + 1; t <= t0 + 2 * h * n; t++) begin
         rel  = t - t0 - 1;
         slot = rel / (2 * h);
         ph   = rel % (2 * h);
         mdioI = 1'b1;
         if (!v.wr && v.phyMode == 0) begin
            if (slot == p + 15) mdioI = 1'b0;
            else if (slot >= p + 16) mdioI = v.phyData[15 - (slot - p - 16)];
         end
         expDrive = v.wr || (slot < p + 14);
         expBit   = (slot < p) ? 1'b1 : v.expFrame[31 - (slot - p)];
         if (selT !== !expDrive) tOk = 1'b0;
         if (expDrive && (selO !== expBit)) bitsOk = 1'b0;
         if (selMdc !== (ph >= h)) mdcOk = 1'b0;
         if (selRsp !== 1'b0 || selReady !== 1'b0) quietOk = 1'b0;
         cmdValid = (t - t0 == v.pulseAt);
         tick();
      end
      cmdValid = 1'b0;
      mdioI = 1'b1;
      checkOutput({name, " mdioBits"}, {31'd0, bitsOk}, 32'd1);
      checkOutput({name, " mdioTristate"}, {31'd0, tOk}, 32'd1);
      checkOutput({name, " mdcWaveform"}, {31'd0, mdcOk}, 32'd1);
      checkOutput({name, " quietDuringFrame"}, {31'd0, quietOk}, 32'd1);
      checkOutput({name, " rspValid"}, {31'd0, selRsp}, 32'd1);
      checkOutput({name, " rspRdata"}, {16'd0, selRdata}, {16'd0, v.expRdata});
      checkOutput({name, " rspError"}, {31'd0, selErr}, {31'd0, v.expErr});
      checkOutput({name, " respondBus"}, {29'd0, selMdc, selT, selO}, 32'b010);
      tick();
      checkOutput({name, " readyAfter"}, {30'd0, selReady, selRsp}, 32'b10);
   endtask

   initial begin
      int t1, t2, r1, r2, t0;
      bit noRsp;
      vec_t v;

      vecs[0] = '{wr: 1'b1, phy: 5'h0C, rg: 5'h04, wdata: 16'hA5F0, expFrame: 32'h5612_A5F0,
                  phyMode: 1, phyData: 16'h0000, pulseAt: 0, expRdata: 16'h0000, expErr: 1'b0};
      vecs[1] = '{wr: 1'b0, phy: 5'h01, rg: 5'h02, wdata: 16'h0000, expFrame: 32'h6088_0000,
                  phyMode: 0, phyData: 16'h1234, pulseAt: 0, expRdata: 16'h1234, expErr: 1'b0};
      vecs[2] = '{wr: 1'b0, phy: 5'h1F, rg: 5'h1F, wdata: 16'h0000, expFrame: 32'h6FFC_0000,
                  phyMode: 1, phyData: 16'h0000, pulseAt: 100, expRdata: 16'hFFFF, expErr: 1'b1};
      vecs[3] = '{wr: 1'b1, phy: 5'h00, rg: 5'h00, wdata: 16'h0000, expFrame: 32'h5002_0000,
                  phyMode: 1, phyData: 16'h0000, pulseAt: 37, expRdata: 16'hFFFF, expErr: 1'b0};
      vecs[4] = '{wr: 1'b0, phy: 5'h1F, rg: 5'h1F, wdata: 16'h0000, expFrame: 32'h6FFC_0000,
                  phyMode: 0, phyData: 16'hBEEF, pulseAt: 0, expRdata: 16'hBEEF, expErr: 1'b0};

      resetN = 1'b0;
      tick(); tick(); tick();
      checkOutput("resetOutputs", {rdataA, 9'd0, readyA, rspValidA, rspErrA, mdcA, mdioOA, mdioTA},
                  {16'h0000, 9'd0, 7'b0000001});
      resetN = 1'b1;
      checkOutput("readyLowAtRelease", {31'd0, readyA}, 32'd0);
      tick();
      checkOutput("readyRisesAfterRelease", {31'd0, readyA}, 32'd1);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i], 1'b0, $sformatf("vec%0d", i));
      end

      // Reset asserted at the start of slot 20 of a read frame.
      useB = 1'b0;
      mdioI = 1'b1;
      cmdWrite = 1'b0; cmdPhy = 5'h02; cmdReg = 5'h03;
      cmdValid = 1'b1;
      t0 = cyc;
      tick();
      cmdValid = 1'b0;
      while (cyc < t0 + 81) tick();
      resetN = 1'b0;
      tick();
      checkOutput("midResetOutputs", {28'd0, mdcA, mdioTA, readyA, rspValidA}, 32'b0100);
      tick();
      resetN = 1'b1;
      noRsp = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (rspValidA) noRsp = 1'b0;
         tick();
      end
      checkOutput("noRspAfterMidReset", {31'd0, noRsp}, 32'd1);
      v = '{wr: 1'b1, phy: 5'h03, rg: 5'h07, wdata: 16'h8001, expFrame: 32'h519E_8001,
            phyMode: 1, phyData: 16'h0000, pulseAt: 0, expRdata: 16'h0000, expErr: 1'b0};
      applyStimulus(v, 1'b0, "postReset");

      // Back-to-back commands with cmd_valid held high.
      useB = 1'b0;
      cmdWrite = 1'b1; cmdPhy = 5'h04; cmdReg = 5'h05; cmdWdata = 16'h00FF;
      cmdValid = 1'b1;
      t1 = cyc; t2 = -1; r1 = -1; r2 = -1;
      for (int i = 0; i < 700 && r2 < 0; i++) begin
         tick();
         if (t2 >= 0 && cyc == t2 + 1) cmdValid = 1'b0;
         if (r1 < 0) begin
            if (rspValidA) r1 = cyc;
         end else if (t2 < 0) begin
            if (readyA) t2 = cyc;
         end else if (rspValidA) begin
            r2 = cyc;
         end
      end
      cmdValid = 1'b0;
      checkOutput("b2bFirstRsp", r1 - t1, 257);
      checkOutput("b2bSecondHandshake", t2 - r1, 1);
      checkOutput("b2bSecondRsp", r2 - t2, 257);
      tick(); tick();

      // Preamble suppression on the H=3 instance: 32-bit frame, rsp at T+193.
      v = '{wr: 1'b1, phy: 5'h05, rg: 5'h11, wdata: 16'h0001, expFrame: 32'h52C6_0001,
            phyMode: 1, phyData: 16'h0000, pulseAt: 0, expRdata: 16'h0000, expErr: 1'b0};
      applyStimulus(v, 1'b1, "noPreamble");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/mdio_master_v2.md
# mdio_master_v2

Parametrised Clause-22 MDIO management master that runs complete read and write frames to any PHY address on a shared MDIO bus. It accepts one command at a time over a valid/ready request port, generates MDC from the system clock with a configurable divider and preamble length, and returns read data and a bus-error flag on a single-cycle response strobe. It sits between the Ethernet management/config logic and the top-level MDIO tristate buffer.

## Interface
- CLKS_PER_HALF_MDC, 63: clk cycles per MDC half-period (H). Legal range is H ≥ 2. The MDC period is 2·H.
- PREAMBLE_BITS, 32: number of leading ones per frame. Legal range is 0..32; 0 means preamble suppression.
- clk  in  1  system clock. This is the only clock.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle and able to accept a command.
- cmd_write  in  1  1 = write frame, 0 = read frame.
- cmd_phy_addr  in  5  target PHY address.
- cmd_reg_addr  in  5  target register address.
- cmd_wdata  in  16  write data (ignored on reads).
- rsp_valid  out  1  one-cycle strobe at frame completion.
- rsp_rdata  out  16  read data. It holds its value until the next read response; it is not updated on writes.
- rsp_error  out  1  read turnaround error. Valid with rsp_valid; always 0 for writes.
- mdc  out  1  management clock.
- mdio_i  in  1  bus input, from the pad.
- mdio_o  out  1  bus output value.
- mdio_t  out  1  tristate enable; 1 = released (high-Z).

## Operation
- The command is latched on the handshake cycle (cmd_valid && cmd_ready). cmd_ready deasserts the following cycle.
- Frame is N = PREAMBLE_BITS + 32 bits, sent MSB first:
  - preamble ones;
  - ST = 01;
  - OP = 10 for read, 01 for write;
  - PHYAD[4:0], then REGAD[4:0];
  - TA: 2 bits;
  - DATA: 16 bits.
- Write frames: the master drives all N bits; TA is driven as 1,0.
- Read frames: the master drives the bits before TA. mdio_t = 1 from the first TA bit through the last data bit.
- States and transitions:
  - IDLE → PREAMBLE on handshake, or directly to HEADER if PREAMBLE_BITS = 0.
  - PREAMBLE → HEADER → TURNAROUND → DATA → RESPOND → IDLE.
  - The bit counter is $clog2(33)+1 bits wide and resets at each state entry.
- Read sampling:
  - The second TA bit is sampled; if it is 1, rsp_error = 1.
  - Data bits shift into rsp_rdata MSB first.
  - The data is still captured on error.
- RESPOND lasts one cycle: rsp_valid = 1, mdc = 0, mdio_t = 1, mdio_o = 0. IDLE and cmd_ready = 1 follow on the next cycle.
- Reset mid-frame:
  - On the next edge, all outputs return to their reset values and the state returns to IDLE.
  - No rsp_valid is issued.
  - The command is discarded.
- cmd_valid while busy is ignored; no queueing.

## Timing
- Reset values (all outputs registered):
  - cmd_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0;
  - mdc = 0, mdio_o = 0, mdio_t = 1.
  - cmd_ready rises on the first cycle after reset_n returns high.
- Let T be the handshake cycle. Bit slot k (0..N-1) occupies cycles T+1+2Hk through T+2H(k+1).
  - mdio_o/mdio_t are updated on the first cycle of the slot, while mdc is low.
  - mdc is high for the last H cycles of the slot.
- mdio_i is sampled on the clk edge at which mdc goes from 0 to 1, i.e. at cycle T+1+2Hk+H.
- MDC is low and idle outside frames; there is no free-running MDC.
- rsp_valid is asserted at cycle T+1+2HN. cmd_ready = 1 at T+2+2HN.
- Minimum spacing between back-to-back handshakes is 2HN+2 cycles.

## Test plan
- **Write frame.** H=2, PREAMBLE_BITS=32; write PHY 0x0C, reg 0x04, data 0xA5F0.
  - mdio_o across slots must read 32×1, 01, 01, 01100, 00100, 10, 1010010111110000.
  - mdio_t = 0 throughout the frame.
  - rsp_valid at T+257 with rsp_error = 0.
- **Read frame, PHY present.** Read PHY 0x01, reg 0x02; the PHY model drives TA = 0 and data 0x1234.
  - mdio_t = 1 from slot 46.
  - rsp_rdata = 0x1234, rsp_error = 0 at T+257.
- **Read frame, no PHY.** Read with mdio_i pulled high throughout.
  - rsp_rdata = 0xFFFF, rsp_error = 1.
- **Preamble suppression.** PREAMBLE_BITS=0, H=3; write data 0x0001.
  - 32-bit frame; ST begins at slot 0.
  - rsp_valid at T+193.
- **Reset mid-frame.** Deassert reset_n at slot 20 of a read.
  - The next cycle shows mdc = 0, mdio_t = 1, cmd_ready = 0.
  - No rsp_valid is issued.
  - After release, a write completes normally.
- **Back-to-back commands.** Hold cmd_valid high for two commands.
  - The second handshake occurs exactly one cycle after rsp_valid.
  - cmd_valid pulses during a frame are ignored.
